// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the
// single-port memory. The arbiter uses the slave view; whatever sits on the
// other side (CPU, bitmap fetch engine, memory) uses the master view.
interface dmem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // CPU load/store path
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  // Bitmap fetch engine (read-only)
  logic          bm_req;
  logic [AW-1:0] bm_addr;
  logic          bm_gnt;
  logic          bm_rvalid;
  logic [DW-1:0] bm_rdata;

  // Single-port memory
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    input  bm_req, bm_addr,
    output bm_gnt, bm_rvalid, bm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    output bm_req, bm_addr,
    input  bm_gnt, bm_rvalid, bm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory sequencer/arbiter. Picks one of CPU or bitmap fetch in IDLE,
// issues the access for one cycle, waits out the read latency, and returns
// the read data to the winner. A starvation counter lets the bitmap fetch
// through after STARVE_MAX consecutive CPU wins while it was waiting.
module dmem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);
  localparam logic [2:0] LAT_LOAD     = 3'(RD_LAT);

  state_t        state;
  logic          ownerBm;
  logic [3:0]    starveCnt;
  logic [2:0]    latCnt;

  logic          cpuGnt;
  logic          bmGnt;
  logic          cpuRvalid;
  logic          bmRvalid;
  logic [DW-1:0] cpuRdata;
  logic [DW-1:0] bmRdata;
  logic          memEn;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;

  logic          cpuWins;

  // CPU has priority unless bm is also asking and has hit its starvation limit.
  always_comb begin
    cpuWins = bus.cpu_req && !(bus.bm_req && (starveCnt == STARVE_LIMIT));
  end

  // Arbitration FSM; all bus-facing outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ownerBm   <= 1'b0;
      starveCnt <= 4'd0;
      latCnt    <= 3'd0;
      cpuGnt    <= 1'b0;
      bmGnt     <= 1'b0;
      cpuRvalid <= 1'b0;
      bmRvalid  <= 1'b0;
      cpuRdata  <= '0;
      bmRdata   <= '0;
      memEn     <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWdata  <= '0;
    end else begin
      // Pulses default low; memory address/data deliberately hold.
      cpuGnt    <= 1'b0;
      bmGnt     <= 1'b0;
      cpuRvalid <= 1'b0;
      bmRvalid  <= 1'b0;
      memEn     <= 1'b0;
      memWe     <= 1'b0;

      case (state)
        IDLE: begin
          if (!bus.bm_req) begin
            starveCnt <= 4'd0;
          end
          if (cpuWins) begin
            ownerBm  <= 1'b0;
            cpuGnt   <= 1'b1;
            memEn    <= 1'b1;
            memWe    <= bus.cpu_we;
            memAddr  <= bus.cpu_addr;
            memWdata <= bus.cpu_wdata;
            state    <= ISSUE;
            if (bus.bm_req && (starveCnt < STARVE_LIMIT)) begin
              starveCnt <= starveCnt + 4'd1;
            end
          end else if (bus.bm_req) begin
            ownerBm   <= 1'b1;
            bmGnt     <= 1'b1;
            memEn     <= 1'b1;
            memWe     <= 1'b0;
            memAddr   <= bus.bm_addr;
            starveCnt <= 4'd0;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          // memWe still reflects the latched direction during ISSUE.
          if (memWe) begin
            state <= IDLE;
          end else begin
            // Loaded with the full latency so the capture in WAIT lands
            // exactly RD_LAT cycles after the mem_en cycle.
            latCnt <= LAT_LOAD;
            state  <= WAIT;
          end
        end

        WAIT: begin
          if (latCnt == 3'd1) begin
            latCnt <= 3'd0;
            state  <= RESP;
            if (ownerBm) begin
              bmRdata  <= bus.mem_rdata;
              bmRvalid <= 1'b1;
            end else begin
              cpuRdata  <= bus.mem_rdata;
              cpuRvalid <= 1'b1;
            end
          end else begin
            latCnt <= latCnt - 3'd1;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_gnt    = cpuGnt;
  assign bus.cpu_rvalid = cpuRvalid;
  assign bus.cpu_rdata  = cpuRdata;
  assign bus.bm_gnt     = bmGnt;
  assign bus.bm_rvalid  = bmRvalid;
  assign bus.bm_rdata   = bmRdata;
  assign bus.mem_en     = memEn;
  assign bus.mem_we     = memWe;
  assign bus.mem_addr   = memAddr;
  assign bus.mem_wdata  = memWdata;

  // Stall drops the cycle a store is granted or load data comes back.
  assign bus.cpu_stall  = bus.cpu_req & ~(cpuGnt & bus.cpu_we) & ~cpuRvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with RD_LAT=2, STARVE_MAX=4. A small
// memory model returns rdValue only in the cycle exactly RD_LAT after a
// read's mem_en cycle and 0xDEAD otherwise, so a mistimed capture shows up.
module tb_dmem_arbiter;

  localparam int AW         = 16;
  localparam int DW         = 16;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] rdValue;
  logic [1:0]    enPipe;
  logic [9:0]    expArb;
  int            testsRun;
  int            testsFailed;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory read pipeline: data valid RD_LAT cycles after a read mem_en cycle.
  always @(posedge clk) begin
    enPipe <= {enPipe[0], bus.mem_en & ~bus.mem_we};
  end
  assign bus.mem_rdata = enPipe[1] ? rdValue : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".cpu_gnt"},    32'(bus.cpu_gnt),    32'h0);
    check({tag, ".bm_gnt"},     32'(bus.bm_gnt),     32'h0);
    check({tag, ".cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'h0);
    check({tag, ".bm_rvalid"},  32'(bus.bm_rvalid),  32'h0);
    check({tag, ".mem_en"},     32'(bus.mem_en),     32'h0);
    check({tag, ".mem_we"},     32'(bus.mem_we),     32'h0);
    check({tag, ".mem_addr"},   32'(bus.mem_addr),   32'h0);
    check({tag, ".mem_wdata"},  32'(bus.mem_wdata),  32'h0);
    check({tag, ".cpu_rdata"},  32'(bus.cpu_rdata),  32'h0);
    check({tag, ".bm_rdata"},   32'(bus.bm_rdata),   32'h0);
    check({tag, ".cpu_stall"},  32'(bus.cpu_stall),  32'h0);
  endtask

  // Wait (bounded) for the next grant and compare its owner.
  task automatic waitGrant(input string tag, input logic expBm);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (bus.cpu_gnt || bus.bm_gnt) found = 1'b1;
    end
    if (!found) begin
      check({tag, ".timeout"}, 32'h0, 32'h1);
    end else begin
      check({tag, ".exclusive"}, 32'(bus.cpu_gnt & bus.bm_gnt), 32'h0);
      check(tag, 32'(bus.bm_gnt), 32'(expBm));
      $display("[TB] %s granted to %s", tag, bus.bm_gnt ? "bm" : "cpu");
    end
  endtask

  initial begin
    bit seen;
    testsRun      = 0;
    testsFailed   = 0;
    rdValue       = 16'h0000;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.bm_req    = 1'b0;
    bus.bm_addr   = '0;
    rst           = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    nextCycle();
    rst = 1'b0;
    nextCycle();
    $display("[TB] reset released");

    // CPU store alone
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'hBEEF;
    @(negedge clk);
    check("st.c0.stall", 32'(bus.cpu_stall), 32'h1);
    check("st.c0.gnt",   32'(bus.cpu_gnt),   32'h0);
    nextCycle();
    @(negedge clk);
    check("st.c1.gnt",    32'(bus.cpu_gnt),   32'h1);
    check("st.c1.mem_en", 32'(bus.mem_en),    32'h1);
    check("st.c1.mem_we", 32'(bus.mem_we),    32'h1);
    check("st.c1.addr",   32'(bus.mem_addr),  32'h0010);
    check("st.c1.wdata",  32'(bus.mem_wdata), 32'hBEEF);
    check("st.c1.stall",  32'(bus.cpu_stall), 32'h0);
    nextCycle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    @(negedge clk);
    check("st.c2.gnt",    32'(bus.cpu_gnt),    32'h0);
    check("st.c2.mem_en", 32'(bus.mem_en),     32'h0);
    check("st.c2.addr",   32'(bus.mem_addr),   32'h0010);
    check("st.c2.rvalid", 32'(bus.cpu_rvalid), 32'h0);
    $display("[TB] store 0x0010 <= 0xBEEF");

    // CPU load, RD_LAT=2
    nextCycle();
    rdValue = 16'h1234;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0020;
    @(negedge clk);
    check("ld.c0.stall", 32'(bus.cpu_stall), 32'h1);
    nextCycle();
    @(negedge clk);
    check("ld.c1.gnt",    32'(bus.cpu_gnt),   32'h1);
    check("ld.c1.mem_we", 32'(bus.mem_we),    32'h0);
    check("ld.c1.addr",   32'(bus.mem_addr),  32'h0020);
    check("ld.c1.stall",  32'(bus.cpu_stall), 32'h1);
    for (int c = 2; c < 4; c++) begin
      nextCycle();
      @(negedge clk);
      check("ld.wait.stall",  32'(bus.cpu_stall),  32'h1);
      check("ld.wait.rvalid", 32'(bus.cpu_rvalid), 32'h0);
    end
    nextCycle();
    @(negedge clk);
    check("ld.c4.rvalid",   32'(bus.cpu_rvalid), 32'h1);
    check("ld.c4.rdata",    32'(bus.cpu_rdata),  32'h1234);
    check("ld.c4.stall",    32'(bus.cpu_stall),  32'h0);
    check("ld.c4.bmRvalid", 32'(bus.bm_rvalid),  32'h0);
    nextCycle();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("ld.c5.rvalid", 32'(bus.cpu_rvalid), 32'h0);
    check("ld.c5.rdata",  32'(bus.cpu_rdata),  32'h1234);
    $display("[TB] load 0x0020 -> 0x%0h", bus.cpu_rdata);

    // bm read alone
    nextCycle();
    rdValue = 16'h00FF;
    bus.bm_req = 1'b1; bus.bm_addr = 16'h0200;
    @(negedge clk);
    check("bm.c0.gnt", 32'(bus.bm_gnt), 32'h0);
    nextCycle();
    @(negedge clk);
    check("bm.c1.gnt",    32'(bus.bm_gnt),   32'h1);
    check("bm.c1.cpuGnt", 32'(bus.cpu_gnt),  32'h0);
    check("bm.c1.mem_en", 32'(bus.mem_en),   32'h1);
    check("bm.c1.mem_we", 32'(bus.mem_we),   32'h0);
    check("bm.c1.addr",   32'(bus.mem_addr), 32'h0200);
    nextCycle();
    bus.bm_req = 1'b0;
    @(negedge clk);
    check("bm.c2.rvalid", 32'(bus.bm_rvalid), 32'h0);
    nextCycle();
    @(negedge clk);
    check("bm.c3.rvalid", 32'(bus.bm_rvalid), 32'h0);
    nextCycle();
    @(negedge clk);
    check("bm.c4.rvalid",    32'(bus.bm_rvalid),  32'h1);
    check("bm.c4.rdata",     32'(bus.bm_rdata),   32'h00FF);
    check("bm.c4.cpuRdata",  32'(bus.cpu_rdata),  32'h1234);
    check("bm.c4.cpuRvalid", 32'(bus.cpu_rvalid), 32'h0);
    nextCycle();
    @(negedge clk);
    check("bm.c5.rvalid", 32'(bus.bm_rvalid), 32'h0);
    $display("[TB] bm read 0x0200 -> 0x%0h", bus.bm_rdata);

    // Continuous contention: C,C,C,C,B,C,C,C,C,B
    nextCycle();
    expArb = 10'b10_0001_0000;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0100;
    bus.bm_req  = 1'b1; bus.bm_addr  = 16'h0300;
    for (int g = 0; g < 10; g++) begin
      waitGrant($sformatf("arb.g%0d", g), expArb[g]);
    end

    // Three CPU wins, then bm_req low for one arbitration clears starvation
    for (int g = 0; g < 3; g++) begin
      waitGrant($sformatf("drop.pre%0d", g), 1'b0);
    end
    nextCycle();
    bus.bm_req = 1'b0;
    waitGrant("drop.gap", 1'b0);
    nextCycle();
    bus.bm_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      waitGrant($sformatf("drop.post%0d", g), 1'b0);
    end
    waitGrant("drop.bm", 1'b1);
    nextCycle();
    bus.cpu_req = 1'b0;
    bus.bm_req  = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (bus.bm_rvalid) seen = 1'b1;
    end
    check("drop.bmRvalid", 32'(seen), 32'h1);

    // Reset while a load is in WAIT
    nextCycle();
    rdValue = 16'h5A5A;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0030;
    nextCycle();
    @(negedge clk);
    check("rstMid.gnt", 32'(bus.cpu_gnt), 32'h1);
    nextCycle();
    bus.cpu_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstMid.waitRvalid", 32'(bus.cpu_rvalid), 32'h0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("rstMid.after");
    for (int c = 0; c < 2; c++) begin
      nextCycle();
      @(negedge clk);
      check("rstMid.noCpuRvalid", 32'(bus.cpu_rvalid), 32'h0);
      check("rstMid.noBmRvalid",  32'(bus.bm_rvalid),  32'h0);
    end
    $display("[TB] reset during WAIT aborted the load");

    // Store after reset completes with normal timing
    nextCycle();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr = 16'h0044; bus.cpu_wdata = 16'hA5A5;
    @(negedge clk);
    check("post.c0.stall", 32'(bus.cpu_stall), 32'h1);
    check("post.c0.gnt",   32'(bus.cpu_gnt),   32'h0);
    nextCycle();
    @(negedge clk);
    check("post.c1.gnt",    32'(bus.cpu_gnt),   32'h1);
    check("post.c1.mem_we", 32'(bus.mem_we),    32'h1);
    check("post.c1.addr",   32'(bus.mem_addr),  32'h0044);
    check("post.c1.wdata",  32'(bus.mem_wdata), 32'hA5A5);
    nextCycle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    @(negedge clk);
    check("post.c2.gnt",    32'(bus.cpu_gnt), 32'h0);
    check("post.c2.mem_en", 32'(bus.mem_en),  32'h0);
    $display("[TB] store 0x0044 <= 0xA5A5");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
